// File: rtl/vga_scan_if.sv
// Renderer/display-side signal bundle of the VGA scan controller.
// master = controller, slave = renderer and DAC side.
interface vga_scan_if;
    logic [18:0] oAddress;
    logic [23:0] iPixel;
    logic [7:0]  oVGA_R;
    logic [7:0]  oVGA_G;
    logic [7:0]  oVGA_B;
    logic        oHS;
    logic        oVS;
    logic        oBlank_n;
    logic        oPixelTick;
    logic        oFrameStart;

    modport master (
        output oAddress, oVGA_R, oVGA_G, oVGA_B, oHS, oVS, oBlank_n, oPixelTick, oFrameStart,
        input  iPixel
    );
    modport slave (
        input  oAddress, oVGA_R, oVGA_G, oVGA_B, oHS, oVS, oBlank_n, oPixelTick, oFrameStart,
        output iPixel
    );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA raster timing generator: drives pixel addresses to the renderer and emits
// RGB/HS/VS/BLANK_N aligned to the returned pixel PIXEL_LATENCY ticks later.
module vga_scan_controller #(
    parameter int CLK_DIV       = 2,
    parameter int PIXEL_LATENCY = 1,
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33
) (
    input  logic       iClock,
    input  logic       iReset,
    vga_scan_if.master bus
);
    localparam int          L          = PIXEL_LATENCY;
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] ADDR_BLANK = 19'(H_ACTIVE * V_ACTIVE - 1);

    logic [3:0]  r_div;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        w_tick;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [18:0] w_addr;

    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_ptick;
    logic        r_fs;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? 4'd0 : r_div + 4'd1;
            if (w_tick) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_raw = !((r_h >= HS_BEG) && (r_h < HS_END));
    assign w_vs_raw = !((r_v >= VS_BEG) && (r_v < VS_END));
    // Blanking parks on the last pixel so address 0 only ever means pixel (0,0).
    assign w_addr   = w_active ? (19'(r_v) * 19'(H_ACTIVE) + 19'(r_h)) : ADDR_BLANK;

    // w_dly[k] = {active,hs,vs} of the position k ticks ago; [0] is the live position.
    logic [L:0][2:0] w_dly;
    assign w_dly[0] = {w_active, w_hs_raw, w_vs_raw};

    for (genvar gi = 1; gi <= L; gi++) begin : g_dly
        logic [2:0] r_stage;
        always_ff @(posedge iClock) begin
            if (iReset)      r_stage <= 3'b011;
            else if (w_tick) r_stage <= w_dly[gi-1];
        end
        assign w_dly[gi] = r_stage;
    end

    // The output registers are the final delay stage, so syncs and RGB share one edge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_rgb     <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_ptick   <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_ptick <= w_tick;
            r_fs    <= w_tick && (r_h == 10'd0) && (r_v == 10'd0);
            if (w_tick) begin
                r_rgb     <= w_dly[L][2] ? bus.iPixel : 24'd0;
                r_blank_n <= w_dly[L][2];
                r_hs      <= w_dly[L][1];
                r_vs      <= w_dly[L][0];
            end
        end
    end

    assign bus.oAddress    = w_addr;
    assign bus.oVGA_R      = r_rgb[23:16];
    assign bus.oVGA_G      = r_rgb[15:8];
    assign bus.oVGA_B      = r_rgb[7:0];
    assign bus.oHS         = r_hs;
    assign bus.oVS         = r_vs;
    assign bus.oBlank_n    = r_blank_n;
    assign bus.oPixelTick  = r_ptick;
    assign bus.oFrameStart = r_fs;
endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: hand-computed vectors on the full 640x480 timing,
// a closed-form cycle model on small geometries, reset-in-sync and frame checks.
module tb_vga_scan_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        int d, l, ha, hf, hw, hb, va, vf, vw, vb;
    } geo_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] rgb;
        logic        hs, vs, bl, pt, fs;
    } obs_t;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic        hs;
        logic        bl;
        logic [23:0] rgb;
        logic        pt;
        logic        fs;
    } vec_t;

    localparam geo_t GF = '{2, 1, 640, 16, 96, 48, 480, 10, 2, 33};
    localparam geo_t G1 = '{2, 1, 8, 2, 3, 2, 4, 1, 2, 1};
    localparam geo_t G0 = '{3, 0, 8, 2, 3, 2, 4, 1, 2, 1};
    localparam geo_t G3 = '{1, 3, 8, 2, 3, 2, 4, 1, 2, 1};

    vga_scan_if bf ();
    vga_scan_if b1 ();
    vga_scan_if b0 ();
    vga_scan_if b3 ();

    vga_scan_controller #(.CLK_DIV(2), .PIXEL_LATENCY(1)) u_full (
        .iClock(clk), .iReset(rst), .bus(bf));
    vga_scan_controller #(.CLK_DIV(2), .PIXEL_LATENCY(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
        .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_s1 (
        .iClock(clk), .iReset(rst), .bus(b1));
    vga_scan_controller #(.CLK_DIV(3), .PIXEL_LATENCY(0), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
        .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_s0 (
        .iClock(clk), .iReset(rst), .bus(b0));
    vga_scan_controller #(.CLK_DIV(1), .PIXEL_LATENCY(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3),
        .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_s3 (
        .iClock(clk), .iReset(rst), .bus(b3));

    obs_t af, a1, a0, a3;
    assign af = {bf.oAddress, bf.oVGA_R, bf.oVGA_G, bf.oVGA_B, bf.oHS, bf.oVS, bf.oBlank_n, bf.oPixelTick, bf.oFrameStart};
    assign a1 = {b1.oAddress, b1.oVGA_R, b1.oVGA_G, b1.oVGA_B, b1.oHS, b1.oVS, b1.oBlank_n, b1.oPixelTick, b1.oFrameStart};
    assign a0 = {b0.oAddress, b0.oVGA_R, b0.oVGA_G, b0.oVGA_B, b0.oHS, b0.oVS, b0.oBlank_n, b0.oPixelTick, b0.oFrameStart};
    assign a3 = {b3.oAddress, b3.oVGA_R, b3.oVGA_G, b3.oVGA_B, b3.oHS, b3.oVS, b3.oBlank_n, b3.oPixelTick, b3.oFrameStart};

    int n_cmp = 0;
    int n_bad = 0;
    int c     = 0;
    bit live  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at c=%0d: got %0h, expected %0h", nm, c, act, exp);
        end
    endtask

    function automatic logic [23:0] enc(input logic [18:0] a);
        return {a[7:0], a[15:8], 5'b0, a[18:16]};
    endfunction

    function automatic logic [18:0] addr_of(input int n, input geo_t g);
        int ht, vt, h, v;
        ht = g.ha + g.hf + g.hw + g.hb;
        vt = g.va + g.vf + g.vw + g.vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        return (h < g.ha && v < g.va) ? 19'(v * g.ha + h) : 19'(g.ha * g.va - 1);
    endfunction

    // Expected outputs during cycle c after the last reset edge.
    function automatic obs_t model(input int cc, input geo_t g);
        obs_t o;
        int ht, vt, n, m, h, v;
        ht   = g.ha + g.hf + g.hw + g.hb;
        vt   = g.va + g.vf + g.vw + g.vb;
        n    = cc / g.d;
        o.addr = addr_of(n, g);
        o.pt   = (cc > 0) && (cc % g.d == 0);
        o.fs   = (cc % (ht * vt * g.d)) == g.d;
        o.hs = 1'b1; o.vs = 1'b1; o.bl = 1'b0; o.rgb = '0;
        m = n - g.l - 1;
        if (m >= 0) begin
            h = m % ht;
            v = (m / ht) % vt;
            o.bl = (h < g.ha) && (v < g.va);
            o.hs = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hw);
            o.vs = !(v >= g.va + g.vf && v < g.va + g.vf + g.vw);
            if (o.bl) o.rgb = enc(19'(v * g.ha + h));
        end
        return o;
    endfunction

    // Renderer: correct pixel only in the sampling cycle, noise everywhere else.
    function automatic logic [23:0] pix(input int cc, input geo_t g);
        if ((cc % g.d) != (g.d - 1) || (cc / g.d) < g.l) return 24'($urandom);
        return enc(addr_of(cc / g.d - g.l, g));
    endfunction

    initial begin
        bf.iPixel = '0; b1.iPixel = '0; b0.iPixel = '0; b3.iPixel = '0;
        forever begin
            @(posedge clk);
            if (rst) begin c = 0; live = 1'b1; end
            else c++;
            #1;
            bf.iPixel = pix(c, GF);
            b1.iPixel = pix(c, G1);
            b0.iPixel = pix(c, G0);
            b3.iPixel = pix(c, G3);
            @(negedge clk);
            if (live) begin
                chk("full_cycle", 64'(af), 64'(model(c, GF)));
                chk("s1_cycle",   64'(a1), 64'(model(c, G1)));
                chk("s0_cycle",   64'(a0), 64'(model(c, G0)));
                chk("s3_cycle",   64'(a3), 64'(model(c, G3)));
            end
        end
    end

    task automatic wait_c(input int target);
        int guard;
        guard = 0;
        while (c != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_cycle", 64'(c), 64'(target));
    endtask

    task automatic frame_stats(input bit sel3, input int exp_cyc, input int exp_bl);
        int guard, cyc, bl;
        obs_t o;
        guard = 0;
        do begin
            @(negedge clk);
            o = sel3 ? a3 : a1;
            guard++;
        end while (!o.fs && guard < 2000);
        cyc = 0; bl = 0;
        do begin
            @(negedge clk);
            o = sel3 ? a3 : a1;
            cyc++;
            if (o.bl) bl++;
        end while (!o.fs && cyc < 2000);
        chk(sel3 ? "s3_frame_period" : "s1_frame_period", 64'(cyc), 64'(exp_cyc));
        chk(sel3 ? "s3_blank_cycles" : "s1_blank_cycles", 64'(bl), 64'(exp_bl));
    endtask

    vec_t tv[14];

    initial begin
        // Full 640x480, CLK_DIV=2, latency 1: position p shows during cycles 2p+4, 2p+5.
        tv[0]  = '{0,    19'd0,      1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
        tv[1]  = '{2,    19'd1,      1'b1, 1'b0, 24'h000000, 1'b1, 1'b1};
        tv[2]  = '{4,    19'd2,      1'b1, 1'b1, 24'h000000, 1'b1, 1'b0};
        tv[3]  = '{5,    19'd2,      1'b1, 1'b1, 24'h000000, 1'b0, 1'b0};
        tv[4]  = '{6,    19'd3,      1'b1, 1'b1, 24'h010000, 1'b1, 1'b0};
        tv[5]  = '{604,  19'd302,    1'b1, 1'b1, 24'h2C0100, 1'b1, 1'b0};
        tv[6]  = '{1282, 19'd307199, 1'b1, 1'b1, 24'h7F0200, 1'b1, 1'b0};
        tv[7]  = '{1284, 19'd307199, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        tv[8]  = '{1314, 19'd307199, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        tv[9]  = '{1316, 19'd307199, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        tv[10] = '{1507, 19'd307199, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tv[11] = '{1508, 19'd307199, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        tv[12] = '{1600, 19'd640,    1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        tv[13] = '{1604, 19'd642,    1'b1, 1'b1, 24'h800200, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            wait_c(tv[i].cyc);
            chk("vec_addr",  64'(bf.oAddress), 64'(tv[i].addr));
            chk("vec_hs",    64'(bf.oHS), 64'(tv[i].hs));
            chk("vec_vs",    64'(bf.oVS), 64'(1'b1));
            chk("vec_blank", 64'(bf.oBlank_n), 64'(tv[i].bl));
            chk("vec_rgb",   64'({bf.oVGA_R, bf.oVGA_G, bf.oVGA_B}), 64'(tv[i].rgb));
            chk("vec_ptick", 64'(bf.oPixelTick), 64'(tv[i].pt));
            chk("vec_fstart", 64'(bf.oFrameStart), 64'(tv[i].fs));
        end

        // Line 2, h=700 on the outputs: sync is low, then reset lands mid-pulse.
        wait_c(4604);
        chk("pre_rst_hs", 64'(bf.oHS), 64'(1'b0));
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_hs",    64'(bf.oHS), 64'(1'b1));
        chk("rst_blank", 64'(bf.oBlank_n), 64'(1'b0));
        chk("rst_rgb",   64'({bf.oVGA_R, bf.oVGA_G, bf.oVGA_B}), 64'(24'h0));
        chk("rst_addr",  64'(bf.oAddress), 64'(19'd0));
        chk("rst_fs",    64'(bf.oFrameStart), 64'(1'b0));
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fs_c1", 64'(bf.oFrameStart), 64'(1'b0));
        chk("post_rst_addr_c1", 64'(bf.oAddress), 64'(19'd0));
        @(negedge clk);
        chk("post_rst_fs_c2", 64'(bf.oFrameStart), 64'(1'b1));
        chk("post_rst_addr_c2", 64'(bf.oAddress), 64'(19'd1));

        // 15x8 ticks per small frame, 8x4 visible.
        frame_stats(1'b1, 120, 32);
        frame_stats(1'b0, 240, 64);

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
